// File: rtl/btn_pkg.sv
// Shared types and helpers for the button gesture classifier.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        LONG_HELD,
        WAIT2,
        PRESS2
    } btn_state_t;

    function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
        return (freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond strobe generator: prescaler over CLK_FREQ/1000 cycles with synchronous clear.
module ms_tick_gen
    import btn_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 200_000_000
) (
    input  logic clk,
    input  logic arst,
    input  logic clr,
    output logic ms_tick
);

    localparam int unsigned PRE = ms_to_cycles(CLK_FREQ, 1);
    localparam int unsigned PW  = (PRE > 1) ? $clog2(PRE) : 1;
    localparam logic [PW-1:0] TERM = PW'(PRE - 1);

    logic [PW-1:0] prescaler;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            prescaler <= '0;
        end else if (clr || (prescaler == TERM)) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign ms_tick = (prescaler == TERM) && !clr;

endmodule

// File: rtl/btn_event_classifier.sv
// Classifies debounced button activity into press/release ticks and
// short-press, long-press and double-click gesture pulses.
module btn_event_classifier
    import btn_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 200_000_000,
    parameter int unsigned LONG_MS  = 1000,
    parameter int unsigned DCLK_MS  = 300
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       db,
    output logic       pressed,
    output logic       press_tick,
    output logic       release_tick,
    output logic       short_press,
    output logic       long_press,
    output logic       double_click,
    output logic [7:0] press_cnt
);

    localparam int unsigned MS_MAX = (LONG_MS > DCLK_MS) ? LONG_MS : DCLK_MS;
    localparam int unsigned MS_W   = $clog2(MS_MAX + 1);
    localparam logic [MS_W-1:0] LONG_N = MS_W'(LONG_MS);
    localparam logic [MS_W-1:0] DCLK_N = MS_W'(DCLK_MS);

    btn_state_t      state, state_n;
    logic            db_q;
    logic            armed;
    logic            rise, fall;
    logic            ms_tick;
    logic            clr;
    logic            short_n, long_n, dbl_n;
    logic [MS_W-1:0] ms_cnt;

    // Edges only count once armed, so a level held through reset is not a press.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            db_q    <= 1'b0;
            armed   <= 1'b0;
            pressed <= 1'b0;
        end else begin
            db_q    <= db;
            armed   <= 1'b1;
            pressed <= db & armed;
        end
    end

    assign rise = db & ~db_q & armed;
    assign fall = ~db & db_q & armed;

    ms_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_ms_tick_gen (
        .clk     (clk),
        .arst    (arst),
        .clr     (clr),
        .ms_tick (ms_tick)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ms_cnt <= '0;
        end else if (clr) begin
            ms_cnt <= '0;
        end else if (ms_tick && (ms_cnt != '1)) begin
            ms_cnt <= ms_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Edges are tested before timeouts so an edge wins a same-cycle tie.
    always_comb begin
        state_n = state;
        short_n = 1'b0;
        long_n  = 1'b0;
        dbl_n   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_n = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    state_n = WAIT2;
                end else if (ms_cnt == LONG_N) begin
                    long_n  = 1'b1;
                    state_n = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (fall) state_n = IDLE;
            end
            WAIT2: begin
                if (rise) begin
                    state_n = PRESS2;
                end else if (ms_cnt == DCLK_N) begin
                    short_n = 1'b1;
                    state_n = IDLE;
                end
            end
            PRESS2: begin
                if (fall) begin
                    dbl_n   = 1'b1;
                    state_n = IDLE;
                end else if (ms_cnt == LONG_N) begin
                    long_n  = 1'b1;
                    state_n = LONG_HELD;
                end
            end
            default: state_n = IDLE;
        endcase
        clr = (state_n != state);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            press_tick   <= 1'b0;
            release_tick <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            press_cnt    <= 8'd0;
        end else begin
            press_tick   <= rise;
            release_tick <= fall;
            short_press  <= short_n;
            long_press   <= long_n;
            double_click <= dbl_n;
            if (rise) press_cnt <= press_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_btn_event_classifier.sv
// Directed bench for btn_event_classifier: expected pulses (kind and cycle)
// are queued as stimulus is driven and matched as the DUT emits them.
module tb_btn_event_classifier;

    localparam int unsigned CLK_FREQ = 10_000;
    localparam int unsigned LONG_MS  = 20;
    localparam int unsigned DCLK_MS  = 5;
    // Pulses are registered one cycle after the evaluating edge: 20 ms * 10 cycles + 1
    // after press_tick for long_press, 5 ms * 10 cycles + 1 after release_tick for short_press.
    localparam int LONG_CYC  = 201;
    localparam int SHORT_CYC = 51;

    localparam int K_PRESS = 0, K_REL = 1, K_SHORT = 2, K_LONG = 3, K_DBL = 4;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       db = 1'b0;
    logic       pressed, press_tick, release_tick, short_press, long_press, double_click;
    logic [7:0] press_cnt;

    btn_event_classifier #(
        .CLK_FREQ (CLK_FREQ),
        .LONG_MS  (LONG_MS),
        .DCLK_MS  (DCLK_MS)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .db           (db),
        .pressed      (pressed),
        .press_tick   (press_tick),
        .release_tick (release_tick),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .press_cnt    (press_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    int  n_press = 0;

    function automatic string kname(input int k);
        case (k)
            K_PRESS: return "press_tick";
            K_REL:   return "release_tick";
            K_SHORT: return "short_press";
            K_LONG:  return "long_press";
            default: return "double_click";
        endcase
    endfunction

    // Monitor: sample just after each rising edge and match pulses against the queue.
    always begin : monitor
        logic [4:0] pulses;
        ev_t        ev;
        @(posedge clk);
        #1;
        cyc++;
        pulses = {double_click, long_press, short_press, release_tick, press_tick};
        for (int k = 0; k < 5; k++) begin
            if (pulses[k]) begin
                if (k == K_PRESS) n_press++;
                tests++;
                assert (q.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_%s: observed pulse at cyc %0d, expected none", kname(k), cyc);
                end
                if (q.size() != 0) begin
                    ev = q.pop_front();
                    tests++;
                    assert ((ev.kind === k) && (ev.cyc === cyc)) else begin
                        fails++;
                        $error("FAIL %s: observed kind %0d at cyc %0d, expected kind %0d at cyc %0d",
                               kname(k), k, cyc, ev.kind, ev.cyc);
                    end
                end
            end
        end
    end

    task automatic push(input int k, input int c);
        ev_t ev;
        ev.kind = k;
        ev.cyc  = c;
        q.push_back(ev);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive db on a falling edge; e is the rising edge that first samples it.
    task automatic set_db(input logic v, output int e);
        @(negedge clk);
        db = v;
        e  = cyc + 1;
    endtask

    // Keep db stable for n sampling edges in total (counting the one from set_db).
    task automatic idle(input int n);
        repeat (n - 1) @(negedge clk);
    endtask

    function automatic logic [13:0] all_outs();
        return {pressed, press_tick, release_tick, short_press, long_press, double_click, press_cnt};
    endfunction

    initial begin : stim
        int e, f, base;
        int exp_cnt;
        exp_cnt = 0;

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(all_outs()), 32'd0);
        arst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: short press
        set_db(1'b1, e); push(K_PRESS, e); exp_cnt++;
        idle(60);
        set_db(1'b0, f); push(K_REL, f); push(K_SHORT, f + SHORT_CYC);
        idle(100);
        check("t1_pressed", 32'(pressed), 32'd0);
        check("t1_press_cnt", 32'(press_cnt), 32'(exp_cnt));

        // 2: long hold, nothing on release
        set_db(1'b1, e); push(K_PRESS, e); push(K_LONG, e + LONG_CYC); exp_cnt++;
        idle(150);
        check("t2_pressed_held", 32'(pressed), 32'd1);
        idle(151);
        set_db(1'b0, f); push(K_REL, f);
        idle(100);
        check("t2_press_cnt", 32'(press_cnt), 32'(exp_cnt));

        // 3: double click
        set_db(1'b1, e); push(K_PRESS, e); exp_cnt++;
        idle(30);
        set_db(1'b0, f); push(K_REL, f);
        idle(20);
        set_db(1'b1, e); push(K_PRESS, e); exp_cnt++;
        idle(30);
        set_db(1'b0, f); push(K_REL, f); push(K_DBL, f);
        idle(100);
        check("t3_press_cnt", 32'(press_cnt), 32'(exp_cnt));

        // 4: second rise lands on the gap-timeout cycle, so the double click wins
        set_db(1'b1, e); push(K_PRESS, e); exp_cnt++;
        idle(30);
        set_db(1'b0, f); push(K_REL, f);
        idle(SHORT_CYC);
        set_db(1'b1, e); push(K_PRESS, e); exp_cnt++;
        check("t4_coincide_edge", 32'(e), 32'(f + SHORT_CYC));
        idle(30);
        set_db(1'b0, f); push(K_REL, f); push(K_DBL, f);
        idle(100);
        // one cycle later the timeout wins instead: short press, then a fresh gesture
        set_db(1'b1, e); push(K_PRESS, e); exp_cnt++;
        idle(30);
        set_db(1'b0, f); push(K_REL, f); push(K_SHORT, f + SHORT_CYC);
        idle(SHORT_CYC + 1);
        set_db(1'b1, e); push(K_PRESS, e); exp_cnt++;
        idle(30);
        set_db(1'b0, f); push(K_REL, f); push(K_SHORT, f + SHORT_CYC);
        idle(100);
        check("t4_press_cnt", 32'(press_cnt), 32'(exp_cnt));

        // 5: level held through reset gives no press_tick
        @(negedge clk);
        db   = 1'b1;
        arst = 1'b1;
        #1;
        check("t5_async_clear", 32'(all_outs()), 32'd0);
        exp_cnt = 0;
        repeat (3) @(negedge clk);
        arst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_pressed_armed", 32'(pressed), 32'd1);
        check("t5_press_cnt", 32'(press_cnt), 32'd0);
        set_db(1'b0, f); push(K_REL, f);
        idle(80);
        // reset in the middle of PRESS1: nothing may follow
        set_db(1'b1, e); push(K_PRESS, e); exp_cnt++;
        idle(30);
        check("t5_cnt_before_rst", 32'(press_cnt), 32'(exp_cnt));
        @(negedge clk);
        arst = 1'b1;
        #1;
        check("t5_mid_gesture_clear", 32'(all_outs()), 32'd0);
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        idle(250);
        set_db(1'b0, f); push(K_REL, f);
        idle(100);
        check("t5_cnt_after_rst", 32'(press_cnt), 32'd0);

        // 6: counter wrap over 256 presses
        base = n_press;
        for (int i = 0; i < 256; i++) begin
            set_db(1'b1, e); push(K_PRESS, e); exp_cnt++;
            idle(3);
            set_db(1'b0, f); push(K_REL, f); push(K_SHORT, f + SHORT_CYC);
            idle(60);
            if (i == 254) check("t6_cnt_255", 32'(press_cnt), 32'd255);
        end
        check("t6_cnt_wrap", 32'(press_cnt), 32'(exp_cnt[7:0]));
        check("t6_press_ticks", 32'(n_press - base), 32'd256);

        idle(20);
        check("scoreboard_drain", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
